mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-requester (CPU, GFX, KBD) round-robin memory arbiter.
// Grants are registered and one-hot. The granted requester's strobe, address
// and write data are routed combinationally to the memory controller.
// Optional feature macro: ARB_TIMEOUT_EN adds a grant-length limit (TIMEOUT
// cycles), a one-cycle TIMEOUT_IRQ pulse on forced release, and an
// eligibility mask that blocks the evicted requester until it drops REQ.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [2:0]        REQ,
    input  logic [2:0]        EN,
    input  logic [2:0]        WE,
    input  logic [3*AW-1:0]   ADDR,
    input  logic [3*DW-1:0]   DATAW,
    output logic [2:0]        GNT,
    output logic [DW-1:0]     DATAR,
    output logic              memEnable,
    output logic              memWrite,
    output logic [AW-1:0]     memAddr,
    output logic [DW-1:0]     memDataW,
    input  logic [DW-1:0]     memDataR,
    output logic              TIMEOUT_IRQ
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [1:0]  owner, owner_next;
    logic [1:0]  ptr, ptr_next;
    logic [2:0]  gnt_next;
    logic [2:0]  eligible;
    logic [1:0]  pick;
    logic        pick_valid;
    logic [2:0]  cand;
    logic        owned;
    logic        owner_req;
    logic [1:0]  ptr_after_owner;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]  cnt, cnt_next;
    logic [2:0]  mask, mask_next;
    logic        irq, irq_next;

    assign eligible    = REQ & ~mask;
    assign TIMEOUT_IRQ = irq;
`else
    assign eligible    = REQ;
    assign TIMEOUT_IRQ = 1'b0;
`endif

    // Owner index 3 is unreachable; treat it as idle so it can never route.
    assign owned = (state == OWNED) && (owner != 2'd3);

    assign DATAR = memDataR;

    assign ptr_after_owner = (owner >= 2'd2) ? 2'd0 : owner + 2'd1;

    // Round-robin search starting at ptr, wrapping modulo 3.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!pick_valid && eligible[cand[1:0]]) begin
                pick       = cand[1:0];
                pick_valid = 1'b1;
            end
        end
    end

    // Route the owner's request signals to the memory port; zero when idle.
    always_comb begin
        memEnable = 1'b0;
        memWrite  = 1'b0;
        memAddr   = '0;
        memDataW  = '0;
        owner_req = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (owned && (owner == 2'(i))) begin
                memEnable = EN[i];
                memWrite  = WE[i];
                memAddr   = ADDR[i*AW +: AW];
                memDataW  = DATAW[i*DW +: DW];
                owner_req = REQ[i];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, release on REQ drop (or timeout).
    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        gnt_next   = GNT;
`ifdef ARB_TIMEOUT_EN
        cnt_next   = cnt;
        mask_next  = mask & REQ;
        irq_next   = 1'b0;
`endif
        if (!owned) begin
            state_next = IDLE;
            gnt_next   = '0;
            if (pick_valid) begin
                state_next = OWNED;
                owner_next = pick;
                gnt_next   = 3'b001 << pick;
`ifdef ARB_TIMEOUT_EN
                cnt_next   = 8'd1;
`endif
            end
        end else if (!owner_req) begin
            state_next = IDLE;
            gnt_next   = '0;
            ptr_next   = ptr_after_owner;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt == 8'(TIMEOUT)) begin
            state_next = IDLE;
            gnt_next   = '0;
            ptr_next   = ptr_after_owner;
            mask_next  = mask_next | (3'b001 << owner);
            irq_next   = 1'b1;
        end else begin
            cnt_next   = cnt + 8'd1;
`endif
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            GNT   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
            mask  <= '0;
            irq   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            owner <= owner_next;
            ptr   <= ptr_next;
            GNT   <= gnt_next;
`ifdef ARB_TIMEOUT_EN
            cnt   <= cnt_next;
            mask  <= mask_next;
            irq   <= irq_next;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT=8).
// Follows ARB_TIMEOUT_EN to pick the timeout or the hold-forever scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      req, en, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] dataw;
    logic [2:0]      gnt;
    logic [DW-1:0]   datar;
    logic            mem_enable, mem_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_dataw;
    logic [DW-1:0]   mem_datar;
    logic            timeout_irq;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .CLK(clk), .RESET_N(rst_n), .REQ(req), .EN(en), .WE(we),
        .ADDR(addr), .DATAW(dataw), .GNT(gnt), .DATAR(datar),
        .memEnable(mem_enable), .memWrite(mem_write), .memAddr(mem_addr),
        .memDataW(mem_dataw), .memDataR(mem_datar), .TIMEOUT_IRQ(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; en = '0; we = '0; addr = '0; dataw = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [2:0] exp_g;
        int         owners [4];
        int         bad;
        owners = '{0, 1, 2, 0};
        mem_datar = 16'hBEEF;

        // Reset state
        do_reset();
        check_eq("rst_gnt", 64'(gnt), 64'h0);
        check_eq("rst_men", 64'(mem_enable), 64'h0);
        check_eq("rst_maddr", 64'(mem_addr), 64'h0);
        check_eq("rst_irq", 64'(timeout_irq), 64'h0);
        check_eq("datar", 64'(datar), 64'hBEEF);

        // GFX alone: one-cycle latency, address routed
        req = 3'b010; en = 3'b010; addr[1*AW +: AW] = 16'h8000; dataw[1*DW +: DW] = 16'h5A5A;
        tick();
        check_eq("gfx_gnt", 64'(gnt), 64'h2);
        check_eq("gfx_addr", 64'(mem_addr), 64'h8000);
        check_eq("gfx_en", 64'(mem_enable), 64'h1);
        check_eq("gfx_dataw", 64'(mem_dataw), 64'h5A5A);
        req = 3'b000;
        tick();
        check_eq("gfx_rel", 64'(gnt), 64'h0);
        check_eq("idle_addr", 64'(mem_addr), 64'h0);
        check_eq("idle_en", 64'(mem_enable), 64'h0);
        // Pointer now at KBD: with CPU and KBD requesting, KBD wins
        req = 3'b101;
        tick();
        check_eq("ptr_kbd", 64'(gnt), 64'h4);

        // Round robin with 4 granted cycles per owner
        do_reset();
        req = 3'b111;
        tick();
        for (int j = 0; j < 4; j++) begin
            exp_g = 3'b001 << owners[j];
            check_eq("rr_grant", 64'(gnt), 64'(exp_g));
            for (int c = 0; c < 3; c++) begin
                tick();
                check_eq("rr_hold", 64'(gnt), 64'(exp_g));
            end
            req[owners[j]] = 1'b0;
            tick();
            check_eq("rr_gap", 64'(gnt), 64'h0);
            req[owners[j]] = 1'b1;
            tick();
        end

        // Non-owner request ignored until owner drops plus one idle cycle
        do_reset();
        req = 3'b001;
        tick();
        check_eq("cpu_own", 64'(gnt), 64'h1);
        req = 3'b101;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("kbd_blocked", 64'(gnt), 64'h1);
        end
        req = 3'b100;
        tick();
        check_eq("kbd_gap", 64'(gnt), 64'h0);
        tick();
        check_eq("kbd_gnt", 64'(gnt), 64'h4);

        // Asynchronous reset in the middle of a CPU write
        do_reset();
        req = 3'b001; en = 3'b001; we = 3'b001; addr[0 +: AW] = 16'h1234;
        tick();
        check_eq("wr_gnt", 64'(gnt), 64'h1);
        check_eq("wr_we", 64'(mem_write), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_gnt", 64'(gnt), 64'h0);
        check_eq("arst_men", 64'(mem_enable), 64'h0);
        check_eq("arst_mwr", 64'(mem_write), 64'h0);
        check_eq("arst_addr", 64'(mem_addr), 64'h0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after 8 cycles, GFX next, CPU masked until REQ drops
        do_reset();
        req = 3'b011;
        tick();
        check_eq("to_gnt", 64'(gnt), 64'h1);
        for (int c = 0; c < 7; c++) begin
            tick();
            check_eq("to_hold", 64'(gnt), 64'h1);
            check_eq("to_noirq", 64'(timeout_irq), 64'h0);
        end
        tick();
        check_eq("to_rel", 64'(gnt), 64'h0);
        check_eq("to_irq", 64'(timeout_irq), 64'h1);
        tick();
        check_eq("to_gfx", 64'(gnt), 64'h2);
        check_eq("to_irq_clr", 64'(timeout_irq), 64'h0);
        req = 3'b001;
        tick();
        check_eq("to_gfx_rel", 64'(gnt), 64'h0);
        tick();
        check_eq("to_masked1", 64'(gnt), 64'h0);
        tick();
        check_eq("to_masked2", 64'(gnt), 64'h0);
        req = 3'b000;
        tick();
        check_eq("to_unmask", 64'(gnt), 64'h0);
        req = 3'b001;
        tick();
        check_eq("to_regrant", 64'(gnt), 64'h1);
`else
        // No timeout: CPU keeps the bus indefinitely
        do_reset();
        req = 3'b011;
        tick();
        check_eq("hold_gnt", 64'(gnt), 64'h1);
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (gnt !== 3'b001 || timeout_irq !== 1'b0) bad++;
        end
        check_eq("hold_1000", 64'(bad), 64'h0);
        check_eq("hold_irq", 64'(timeout_irq), 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
